// File: rtl/osd_ctm_mor1kx_trace_qual_pkg.sv
// Shared OSD definitions: mor1kx trace sample, OR1K opcodes and CTM control-event record.
package opensocdebug;

    localparam logic [5:0] OR1K_OP_JAL  = 6'h01;
    localparam logic [5:0] OR1K_OP_BNF  = 6'h03;
    localparam logic [5:0] OR1K_OP_BF   = 6'h04;
    localparam logic [5:0] OR1K_OP_JR   = 6'h11;
    localparam logic [5:0] OR1K_OP_JALR = 6'h12;
    localparam logic [4:0] OR1K_REG_LR  = 5'd9;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] npc;
        logic [31:0] insn;
    } mor1kx_trace_exec;

    // Fields sized for the widest supported build; users keep the low ADDR_WIDTH/TIME_WIDTH bits
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] npc;
        logic        jal;
        logic        jalr;
        logic        branch;
        logic        br_taken;
        logic [63:0] tstamp;
    } ctm_ctrl_event_t;

    typedef enum logic [1:0] {
        BR_IDLE,
        BR_DSLOT,
        BR_TARGET
    } br_state_e;

endpackage

// File: rtl/osd_ctm_mor1kx_trace_qual_br_resolve.sv
// Conditional-branch resolver: skips the delay slot and resolves taken/not-taken on the next sample.
module osd_ctm_mor1kx_br_resolve
    import opensocdebug::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned TIME_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sample_valid,
    input  logic [ADDR_WIDTH-1:0] sample_pc,
    input  logic                  sample_branch,
    input  logic [TIME_WIDTH-1:0] cnt,
    output logic                  res_valid,
    output ctm_ctrl_event_t       res_ev
);

    br_state_e             state, state_nxt;
    logic                  capture;
    logic [ADDR_WIDTH-1:0] br_pc;
    logic [TIME_WIDTH-1:0] br_time;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= BR_IDLE;
            br_pc   <= '0;
            br_time <= '0;
        end else begin
            state <= state_nxt;
            if (capture) begin
                br_pc   <= sample_pc;
                br_time <= cnt;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        res_valid = 1'b0;
        if (sample_valid) begin
            case (state)
                BR_IDLE: begin
                    if (sample_branch) begin
                        capture   = 1'b1;
                        state_nxt = BR_DSLOT;
                    end
                end
                BR_DSLOT: state_nxt = BR_TARGET;
                BR_TARGET: begin
                    res_valid = 1'b1;
                    // A branch at the target restarts resolution immediately
                    if (sample_branch) begin
                        capture   = 1'b1;
                        state_nxt = BR_DSLOT;
                    end else begin
                        state_nxt = BR_IDLE;
                    end
                end
                default: state_nxt = BR_IDLE;
            endcase
        end
    end

    always_comb begin
        res_ev          = '0;
        res_ev.pc       = 32'(br_pc);
        res_ev.npc      = 32'(sample_pc);
        res_ev.branch   = 1'b1;
        res_ev.br_taken = (sample_pc != br_pc + ADDR_WIDTH'(8));
        res_ev.tstamp   = 64'(br_time);
    end

endmodule

// File: rtl/osd_ctm_mor1kx_trace_qual.sv
// mor1kx -> CTM trace qualifier: emits timestamped calls/returns, and branches when
// OSD_CTM_MOR1KX_TRACE_QUAL_BRANCH_EN is defined.
module osd_ctm_mor1kx_trace_qual
    import opensocdebug::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned TIME_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  mor1kx_trace_exec      trace_port,
    output logic                  trace_valid,
    output logic [ADDR_WIDTH-1:0] trace_pc,
    output logic [ADDR_WIDTH-1:0] trace_npc,
    output logic                  trace_jal,
    output logic                  trace_jalr,
    output logic                  trace_branch,
    output logic                  trace_br_taken,
    output logic [TIME_WIDTH-1:0] trace_time,
    output logic                  overflow
);

    logic [TIME_WIDTH-1:0] cnt;
    logic [5:0]            opcode;
    logic                  is_call, is_ret, is_new;
    ctm_ctrl_event_t       new_ev, res_ev, hold_ev, out_ev, emit_ev;
    logic                  res_valid, hold_valid, out_valid;
    logic                  emit, hold_load, hold_clr, drop;

    assign opcode  = trace_port.insn[31:26];
    assign is_call = trace_port.valid && (opcode == OR1K_OP_JAL || opcode == OR1K_OP_JALR);
    assign is_ret  = trace_port.valid && opcode == OR1K_OP_JR &&
                     trace_port.insn[15:11] == OR1K_REG_LR;
    assign is_new  = is_call || is_ret;

    always_comb begin
        new_ev        = '0;
        new_ev.pc     = 32'(trace_port.pc[ADDR_WIDTH-1:0]);
        new_ev.npc    = 32'(trace_port.npc[ADDR_WIDTH-1:0]);
        new_ev.jal    = is_call;
        new_ev.jalr   = is_ret;
        new_ev.tstamp = 64'(cnt);
    end

`ifdef OSD_CTM_MOR1KX_TRACE_QUAL_BRANCH_EN
    logic is_branch;
    assign is_branch = trace_port.valid && (opcode == OR1K_OP_BNF || opcode == OR1K_OP_BF);

    osd_ctm_mor1kx_br_resolve #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .TIME_WIDTH(TIME_WIDTH)
    ) u_br_resolve (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (trace_port.valid),
        .sample_pc    (trace_port.pc[ADDR_WIDTH-1:0]),
        .sample_branch(is_branch),
        .cnt          (cnt),
        .res_valid    (res_valid),
        .res_ev       (res_ev)
    );

    assign trace_branch   = out_ev.branch;
    assign trace_br_taken = out_ev.br_taken;
`else
    assign res_valid      = 1'b0;
    assign res_ev         = '0;
    assign trace_branch   = 1'b0;
    assign trace_br_taken = 1'b0;
`endif

    // One slot per cycle: resolved branch > held event > new call/return
    always_comb begin
        emit      = 1'b0;
        emit_ev   = '0;
        hold_load = 1'b0;
        hold_clr  = 1'b0;
        drop      = 1'b0;
        if (res_valid) begin
            emit    = 1'b1;
            emit_ev = res_ev;
        end else if (hold_valid) begin
            emit     = 1'b1;
            emit_ev  = hold_ev;
            hold_clr = 1'b1;
        end else if (is_new) begin
            emit    = 1'b1;
            emit_ev = new_ev;
        end
        if (is_new && (res_valid || hold_valid)) begin
            if (hold_valid) drop = 1'b1;
            else            hold_load = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            hold_valid <= 1'b0;
            hold_ev    <= '0;
            out_valid  <= 1'b0;
            out_ev     <= '0;
            overflow   <= 1'b0;
        end else begin
            cnt       <= cnt + TIME_WIDTH'(1);
            out_valid <= emit;
            if (emit) out_ev <= emit_ev;
            if (hold_load) begin
                hold_valid <= 1'b1;
                hold_ev    <= new_ev;
            end else if (hold_clr) begin
                hold_valid <= 1'b0;
            end
            if (drop) overflow <= 1'b1;
        end
    end

    assign trace_valid = out_valid;
    assign trace_pc    = out_ev.pc[ADDR_WIDTH-1:0];
    assign trace_npc   = out_ev.npc[ADDR_WIDTH-1:0];
    assign trace_jal   = out_ev.jal;
    assign trace_jalr  = out_ev.jalr;
    assign trace_time  = out_ev.tstamp[TIME_WIDTH-1:0];

    logic unused_bits;
    assign unused_bits = ^{trace_port, out_ev};

endmodule
